// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four clients and the round-robin arbiter.
// master = client side (drives req), slave = arbiter side (drives the grant).
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;

    modport master (output req, input gnt, input gnt_idx, input gnt_valid);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-client round-robin arbiter driving a shared 2-to-4 decoder; grant one edge after a
// request is seen in IDLE, bounded hold of HOLD_MAX cycles, no preemption, one idle cycle per handover.
module rr_arbiter_4 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_4_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [0:0] state;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [7:0] hold_cnt;
    logic [1:0] winner;
    logic       any_req;
    logic       release_now;

    // Scan from the farthest candidate back towards ptr so the one closest to ptr wins.
    always_comb begin
        winner = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[ptr + k[1:0]]) begin
                winner = ptr + k[1:0];
            end
        end
    end

    assign any_req     = |bus.req;
    assign release_now = !bus.req[owner] || (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner    <= winner;
                        hold_cnt <= 8'd0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        ptr   <= owner + 2'd1;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_valid = (state == GRANT);
    assign bus.gnt_idx   = owner;
    assign bus.gnt       = (state == GRANT) ? (4'b0001 << owner) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed vector table, closed-form contention/timeout sequences,
// and randomized traffic against a behavioural model, on HOLD_MAX = 8 and HOLD_MAX = 2 instances.
module tb_rr_arbiter_4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arbiter_4_if if8 ();
    rr_arbiter_4_if if2 ();

    rr_arbiter_4 #(.HOLD_MAX(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    rr_arbiter_4 #(.HOLD_MAX(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state, index 0 = HOLD_MAX 8 instance, 1 = HOLD_MAX 2 instance.
    int m_busy  [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_held  [2];
    int hmax    [2] = '{8, 2};

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input int d, input logic r, input logic [3:0] rq);
        if (r) begin
            m_busy[d] = 0; m_owner[d] = 0; m_ptr[d] = 0; m_held[d] = 0;
        end else if (m_busy[d] != 0) begin
            if (!rq[m_owner[d]] || (m_held[d] + 1 >= hmax[d])) begin
                m_busy[d] = 0;
                m_ptr[d]  = (m_owner[d] + 1) % 4;
            end else begin
                m_held[d] = m_held[d] + 1;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (rq[(m_ptr[d] + k) % 4]) begin
                    m_owner[d] = (m_ptr[d] + k) % 4;
                    m_busy[d]  = 1;
                    m_held[d]  = 0;
                    break;
                end
            end
        end
    endfunction

    task automatic chk_model(input int d);
        logic [3:0] g;
        logic [1:0] ix;
        logic       v;
        int         exp_g;
        if (d == 0) begin g = if8.gnt; ix = if8.gnt_idx; v = if8.gnt_valid; end
        else        begin g = if2.gnt; ix = if2.gnt_idx; v = if2.gnt_valid; end
        exp_g = (m_busy[d] != 0) ? (1 << m_owner[d]) : 0;
        chk($sformatf("model_gnt[%0d]", d), int'(g), exp_g);
        chk($sformatf("model_idx[%0d]", d), int'(ix), m_owner[d]);
        chk($sformatf("model_vld[%0d]", d), int'(v), m_busy[d]);
        chk($sformatf("onehot0[%0d]", d), int'($onehot0(g)), 1);
        chk($sformatf("gnt_vs_vld[%0d]", d), int'(g != 4'b0000), int'(v));
    endtask

    // One clock: model sees the inputs sampled at the rising edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, rst, if8.req);
        model_step(1, rst, if2.req);
        @(negedge clk);
        chk_model(0);
        chk_model(1);
    endtask

    initial begin
        int last;
        logic prev_vld;
        int p;

        //          rst   req      gnt      idx   vld
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0};
        tbl[12] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};
        tbl[14] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1};
        tbl[15] = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0};
        tbl[16] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[17] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0};

        rst = 1'b1;
        if8.req = 4'b0000;
        if2.req = 4'b0000;

        for (int i = 0; i < 18; i++) begin
            rst     = tbl[i].rst;
            if8.req = tbl[i].req;
            tick();
            chk($sformatf("vec%0d_gnt", i), int'(if8.gnt), int'(tbl[i].gnt));
            chk($sformatf("vec%0d_idx", i), int'(if8.gnt_idx), int'(tbl[i].idx));
            chk($sformatf("vec%0d_vld", i), int'(if8.gnt_valid), int'(tbl[i].vld));
        end

        // Full contention on HOLD_MAX = 8: 8 grant cycles + 1 idle, owners rotate 0,1,2,3.
        rst = 1'b1; if8.req = 4'b0000; if2.req = 4'b0000;
        tick();
        rst = 1'b0; if8.req = 4'b1111;
        for (int t = 1; t <= 50; t++) begin
            tick();
            p = (t - 1) % 9;
            chk($sformatf("contend_vld_t%0d", t), int'(if8.gnt_valid), int'(p < 8));
            chk($sformatf("contend_gnt_t%0d", t), int'(if8.gnt),
                (p < 8) ? (1 << (((t - 1) / 9) % 4)) : 0);
        end
        if8.req = 4'b0000;

        // Timeout fairness on HOLD_MAX = 2: 2 grant cycles + 1 idle, owners alternate 0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0; if2.req = 4'b0011;
        last = -1;
        prev_vld = 1'b0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            p = (t - 1) % 3;
            chk($sformatf("fair_vld_t%0d", t), int'(if2.gnt_valid), int'(p < 2));
            chk($sformatf("fair_gnt_t%0d", t), int'(if2.gnt),
                (p < 2) ? (1 << (((t - 1) / 3) % 2)) : 0);
            if (if2.gnt_valid && !prev_vld) begin
                if (last >= 0) chk($sformatf("fair_no_repeat_t%0d", t), int'(int'(if2.gnt_idx) != last), 1);
                last = int'(if2.gnt_idx);
            end
            prev_vld = if2.gnt_valid;
        end
        if2.req = 4'b0000;

        // Randomized traffic; requests persist for several cycles so holds and timeouts occur.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) if8.req = 4'($urandom);
            if ($urandom_range(0, 3) == 0) if2.req = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
